// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MIPS mult/div engine owning the Hi/Lo result path.
// Signed multiply uses radix-2 Booth; signed divide uses restoring division on
// magnitudes, with sign correction applied on the last iteration.
// Optional feature macro: MULDIV_UNSIGNED_EN adds op_unsigned (multu/divu).
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_load,
  output logic             lo_load,
  output logic             divby0
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // Operand / accumulator state
  logic [WIDTH:0]   acc;     // Booth accumulator, one guard bit for carry/sign
  logic [WIDTH-1:0] mq;      // multiplier, or dividend shifting into quotient
  logic             q_m1;    // Booth q[-1]
  logic [WIDTH-1:0] mcand;   // multiplicand, or divisor magnitude
  logic [WIDTH-1:0] rem;     // partial remainder
  logic             q_neg;
  logic             r_neg;
  logic             dz;      // divide-by-zero in flight
  logic             uns;     // operation latched as unsigned

  logic             op_uns;
  logic             is_zero_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Step datapath signals
  logic [WIDTH:0]   addend, sum;
  logic             shift_in;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mq_mul_n;
  logic             qm1_n;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_n, mq_div_n, quo_fix, rem_fix;

`ifdef MULDIV_UNSIGNED_EN
  assign op_uns = op_unsigned;
`else
  assign op_uns = 1'b0;
`endif

  assign is_zero_b = (op_b == '0);
  assign mag_a     = (!op_uns && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b     = (!op_uns && op_b[WIDTH-1]) ? -op_b : op_b;
  assign last      = (cnt == CNT_W'(WIDTH-1));

  // Status strobes decode straight from state so reset drops them immediately
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign hi_load = done && !dz;
  assign lo_load = done && !dz;
  assign divby0  = done && dz;

  // One multiply step (Booth or plain shift-add) and one restoring-divide step
  always_comb begin
    addend = '0;
    if (uns) begin
      if (mq[0]) addend = {1'b0, mcand};
    end else begin
      case ({mq[0], q_m1})
        2'b01:   addend = {mcand[WIDTH-1], mcand};
        2'b10:   addend = -{mcand[WIDTH-1], mcand};
        default: addend = '0;
      endcase
    end
    sum      = acc + addend;
    // Unsigned: guard bit is the carry and must shift down with a zero fill
    shift_in = uns ? 1'b0 : sum[WIDTH];
    {acc_n, mq_mul_n, qm1_n} = {shift_in, sum, mq};

    trial = {rem, mq[WIDTH-1]};
    diff  = {1'b0, trial} - {2'b00, mcand};
    q_bit = !diff[WIDTH+1];
    rem_n = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    mq_div_n = {mq[WIDTH-2:0], q_bit};
    quo_fix  = q_neg ? -mq_div_n : mq_div_n;
    rem_fix  = r_neg ? -rem_n : rem_n;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a zero divisor spends one DIV cycle so DONE lands after edge k+1
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_n = MULT;
        else if (start_div) state_n = DIV;
      end
      MULT: if (last) state_n = DONE;
      DIV:  if (dz || last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration and result commit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      q_m1   <= 1'b0;
      mcand  <= '0;
      rem    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      uns    <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc   <= '0;
            mq    <= op_b;
            q_m1  <= 1'b0;
            mcand <= op_a;
            uns   <= op_uns;
            cnt   <= '0;
            dz    <= 1'b0;
          end else if (start_div) begin
            uns <= op_uns;
            cnt <= '0;
            dz  <= is_zero_b;
            if (!is_zero_b) begin
              rem   <= '0;
              mq    <= mag_a;
              mcand <= mag_b;
              q_neg <= !op_uns && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              r_neg <= !op_uns && op_a[WIDTH-1];
            end
          end
        end
        MULT: begin
          acc  <= acc_n;
          mq   <= mq_mul_n;
          q_m1 <= qm1_n;
          cnt  <= last ? '0 : cnt + 1'b1;
          if (last) begin
            hi_out <= acc_n[WIDTH-1:0];
            lo_out <= mq_mul_n;
          end
        end
        DIV: begin
          if (!dz) begin
            rem <= rem_n;
            mq  <= mq_div_n;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs a
// plain-arithmetic reference model, and hand sequences for overlap and reset.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clock = 0;
  logic         reset = 1;
  logic         start_mult = 0, start_div = 0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, hi_load, lo_load, divby0;
  logic [W-1:0] hi_out, lo_out;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi_out(hi_out),
    .lo_out(lo_out), .hi_load(hi_load), .lo_load(lo_load), .divby0(divby0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic m; logic d; logic [W-1:0] a; logic [W-1:0] b;
    logic [W-1:0] hi; logic [W-1:0] lo; string name;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; zero divisor keeps previous Hi/Lo
  task automatic model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (m) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      hi = last_hi;
      lo = last_lo;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Issue one operation and check latency, strobes and results; glitch>0 pulses
  // start_div with a zero divisor at that cycle of the operation.
  task automatic do_op(input logic m, input logic d, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input int glitch, input string nm);
    logic edz;
    int   elat, n;
    logic got, stray, s_dz, s_hl, s_ll;
    logic [W-1:0] s_hi, s_lo;
    edz  = d && !m && (b == '0);
    elat = edz ? 2 : W + 1;
    @(negedge clock);
    start_mult = m; start_div = d; op_a = a; op_b = b;
    @(posedge clock); #1;
    start_mult = 0; start_div = 0; op_a = $urandom; op_b = $urandom;
    n = 0; got = 0; stray = 0;
    s_dz = 0; s_hl = 0; s_ll = 0; s_hi = '0; s_lo = '0;
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      if (glitch > 0 && n == glitch) begin start_div = 1; op_b = '0; end
      else start_div = 0;
      if (done) begin
        got = 1;
        s_dz = divby0; s_hl = hi_load; s_ll = lo_load; s_hi = hi_out; s_lo = lo_out;
      end else if (divby0 || hi_load || lo_load || !busy) stray = 1;
    end
    start_div = 0;
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " stray strobe"}, 64'(stray), 64'd0);
    chk({nm, " divby0"}, 64'(s_dz), 64'(edz));
    chk({nm, " loads"}, {62'd0, s_hl, s_ll}, edz ? 64'd0 : 64'd3);
    chk({nm, " hi"}, 64'(s_hi), 64'(ehi));
    chk({nm, " lo"}, 64'(s_lo), 64'(elo));
    @(negedge clock);
    chk({nm, " idle after"}, {62'd0, busy, done}, 64'd0);
    last_hi = ehi;
    last_lo = elo;
  endtask

  vec_t vt[$];

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic rm, rd;

    vt.push_back('{1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul 7*-3"});
    vt.push_back('{1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mul min*min"});
    vt.push_back('{0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"});
    vt.push_back('{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"});
    vt.push_back('{0, 1, 32'd100,      32'd7,        32'd2,        32'd14,       "div 100/7"});
    vt.push_back('{0, 1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div 7/-2"});
    vt.push_back('{0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        "div -7/-2"});
    vt.push_back('{1, 1, 32'd6,        32'd7,        32'd0,        32'd42,       "both starts"});
    vt.push_back('{1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        "mul -1*-1"});
    vt.push_back('{1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mul max*max"});
    vt.push_back('{1, 0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, "mul min*1"});

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset strobes", {59'd0, busy, done, hi_load, lo_load, divby0}, 64'd0);
    chk("reset hilo", {hi_out, lo_out}, 64'd0);
    reset = 0;

    foreach (vt[i])
      do_op(vt[i].m, vt[i].d, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 0, vt[i].name);

    // Divide by zero: Hi/Lo hold the previous result, no loads
    do_op(0, 1, 32'h12345678, 32'd0, last_hi, last_lo, 0, "div by zero");

    // start_div (zero divisor) pulsed mid-multiply is ignored
    do_op(1, 0, 32'd5, 32'd6, 32'd0, 32'd30, 10, "overlap");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rm = $urandom_range(0, 1);
      rd = !rm || ($urandom_range(0, 3) == 0);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      model(rm, ra, rb, eh, el);
      do_op(rm, rd, ra, rb, eh, el, 0, "random");
    end

    // Reset in the middle of a divide
    @(negedge clock);
    start_div = 1; op_a = 32'hFFFF0000; op_b = 32'd3;
    @(posedge clock); #1;
    start_div = 0;
    repeat (15) @(negedge clock);
    reset = 1;
    #1;
    chk("midreset strobes", {59'd0, busy, done, hi_load, lo_load, divby0}, 64'd0);
    chk("midreset hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clock);
    reset = 0;
    begin
      logic seen;
      seen = 0;
      repeat (40) begin
        @(negedge clock);
        if (busy || done || hi_load || lo_load || divby0) seen = 1;
      end
      chk("midreset quiet", 64'(seen), 64'd0);
    end
    last_hi = '0;
    last_lo = '0;
    do_op(1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, "mul 3*4 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
